// File: rtl/cm_counter_pkg.sv
// Shared types for the down-counter chain.
//   cm_slice_t  : one counter slice at the default slice width
//   SLICE_ONES  : all-ones value of a default-width slice
//   cm_op_e     : per-edge operation chosen once at top level and
//                 broadcast to every slice
package cm_counter_pkg;

    localparam int CM_SLICE_W = 4;

    typedef logic [CM_SLICE_W-1:0] cm_slice_t;

    localparam cm_slice_t SLICE_ONES = '1;

    typedef enum logic [2:0] {
        OP_HOLD   = 3'd0,
        OP_LOAD   = 3'd1,
        OP_DEC    = 3'd2,
        OP_RELOAD = 3'd3,
        OP_WRAP   = 3'd4
    } cm_op_e;

endpackage

// File: rtl/cm_down_slice.sv
// One SLICE_W-bit slice of the down-counter chain.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load        : parallel-load strobe (takes data_slice)
//   op          : operation decided at top level for this edge
//   en_p        : parallel count enable
//   t_in        : borrow-in enable from the lower slice
//   data_slice  : this slice's share of the load / reload value
//   q_slice     : slice value
//   t_out       : borrow-out enable, t_in & (slice == 0)
module cm_down_slice
    import cm_counter_pkg::*;
#(
    parameter int SLICE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  cm_op_e             op,
    input  logic               en_p,
    input  logic               t_in,
    input  logic [SLICE_W-1:0] data_slice,
    output logic [SLICE_W-1:0] q_slice,
    output logic               t_out
);

    logic [SLICE_W-1:0] q_slice_d;
    logic [SLICE_W-1:0] q_slice_q;

    always_comb begin
        q_slice_d = q_slice_q;
        if (load) begin
            q_slice_d = data_slice;
        end else begin
            case (op)
                OP_LOAD:   q_slice_d = data_slice;
                OP_RELOAD: q_slice_d = data_slice;
                OP_WRAP:   q_slice_d = '1;
                OP_DEC: begin
                    // Only slices whose lower neighbours are all zero borrow.
                    if (en_p && t_in) begin
                        q_slice_d = q_slice_q - 1'b1;
                    end
                end
                default:   q_slice_d = q_slice_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_slice_q <= '0;
        end else begin
            q_slice_q <= q_slice_d;
        end
    end

    assign q_slice = q_slice_q;
    assign t_out   = t_in & (q_slice_q == '0);

endmodule

// File: rtl/cm_down_counter_chain.sv
// Cascadable, presettable down-counter chain built from NUM_SLICES slices.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load        : parallel-load strobe, q <= load_val
//   load_val    : W-bit load value
//   reload_we   : write strobe for the reload register
//   reload_val  : reload register data
//   en_p        : count enable (all slices)
//   en_t        : borrow-in enable into slice 0
//   q           : current count
//   tc          : en_t & (q == 0), combinational, for external cascade
//   zero_pulse  : one-cycle pulse the cycle after each underflow
//   busy        : q != 0
module cm_down_counter_chain
    import cm_counter_pkg::*;
#(
    parameter int SLICE_W     = 4,
    parameter int NUM_SLICES  = 2,
    parameter int AUTO_RELOAD = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [SLICE_W*NUM_SLICES-1:0] load_val,
    input  logic                          reload_we,
    input  logic [SLICE_W*NUM_SLICES-1:0] reload_val,
    input  logic                          en_p,
    input  logic                          en_t,
    output logic [SLICE_W*NUM_SLICES-1:0] q,
    output logic                          tc,
    output logic                          zero_pulse,
    output logic                          busy
);

    localparam int W = SLICE_W * NUM_SLICES;

    logic [W-1:0]        reload_d;
    logic [W-1:0]        reload_q;
    logic                zero_pulse_d;
    logic                zero_pulse_q;
    logic                underflow;
    logic [W-1:0]        data_mux;
    logic [NUM_SLICES:0] t_chain;
    cm_op_e              op;

    // The end of the borrow chain is en_t with every slice at zero,
    // which is exactly the terminal count.
    assign t_chain[0] = en_t;
    assign tc         = t_chain[NUM_SLICES];
    assign underflow  = en_p & tc & ~load;

    always_comb begin
        op = OP_HOLD;
        if (load) begin
            op = OP_LOAD;
        end else if (underflow) begin
            op = (AUTO_RELOAD != 0) ? OP_RELOAD : OP_WRAP;
        end else if (en_p && en_t) begin
            op = OP_DEC;
        end
    end

    // reload_q is the pre-write value, so a same-edge reload_we does not
    // affect an underflow on that edge.
    assign data_mux = load ? load_val : reload_q;

    always_comb begin
        reload_d     = reload_we ? reload_val : reload_q;
        zero_pulse_d = underflow;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reload_q     <= '0;
            zero_pulse_q <= 1'b0;
        end else begin
            reload_q     <= reload_d;
            zero_pulse_q <= zero_pulse_d;
        end
    end

    for (genvar k = 0; k < NUM_SLICES; k++) begin : g_slice
        cm_down_slice #(
            .SLICE_W (SLICE_W)
        ) u_slice (
            .clk        (clk),
            .rst        (rst),
            .load       (load),
            .op         (op),
            .en_p       (en_p),
            .t_in       (t_chain[k]),
            .data_slice (data_mux[k*SLICE_W +: SLICE_W]),
            .q_slice    (q[k*SLICE_W +: SLICE_W]),
            .t_out      (t_chain[k+1])
        );
    end

    assign zero_pulse = zero_pulse_q;
    assign busy       = (q != '0);

endmodule

// File: tb/tb_cm_down_counter_chain.sv
module tb_cm_down_counter_chain;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = '0;
    logic       reload_we = 1'b0;
    logic [7:0] reload_val = '0;
    logic       en_p = 1'b0;
    logic       en_t = 1'b0;

    logic [7:0] q_a, q_w;
    logic       tc_a, tc_w, zp_a, zp_w, busy_a, busy_w;

    always #5 clk = ~clk;

    // Auto-reload instance
    cm_down_counter_chain #(.SLICE_W(4), .NUM_SLICES(2), .AUTO_RELOAD(1)) u_dut_a (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .reload_we(reload_we), .reload_val(reload_val),
        .en_p(en_p), .en_t(en_t),
        .q(q_a), .tc(tc_a), .zero_pulse(zp_a), .busy(busy_a)
    );

    // Wrap-to-all-ones instance
    cm_down_counter_chain #(.SLICE_W(4), .NUM_SLICES(2), .AUTO_RELOAD(0)) u_dut_w (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .reload_we(reload_we), .reload_val(reload_val),
        .en_p(en_p), .en_t(en_t),
        .q(q_w), .tc(tc_w), .zero_pulse(zp_w), .busy(busy_w)
    );

    typedef struct packed {
        logic [7:0] q;
        logic       zp;
        logic       busy;
    } exp_t;

    exp_t exp_a_q[$];
    exp_t exp_w_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_qa = '0, m_qw = '0, m_rel = '0;
    logic       m_zpa = 1'b0, m_zpw = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, check tc before the edge, push the model's
    // prediction, then pop and compare after the edge.
    task automatic step(input logic i_rst, input logic i_load, input logic [7:0] i_lv,
                        input logic i_rwe, input logic [7:0] i_rv,
                        input logic i_enp, input logic i_ent, input string tag);
        logic uf_a, uf_w;
        exp_t ea, ew, pa, pw;
        rst = i_rst; load = i_load; load_val = i_lv;
        reload_we = i_rwe; reload_val = i_rv; en_p = i_enp; en_t = i_ent;
        #1;
        check({tag, ".tc_a"}, {31'd0, tc_a}, {31'd0, i_ent && (m_qa == 8'h00)});
        check({tag, ".tc_w"}, {31'd0, tc_w}, {31'd0, i_ent && (m_qw == 8'h00)});

        if (i_rst) begin
            m_qa = '0; m_qw = '0; m_rel = '0; m_zpa = 0; m_zpw = 0;
        end else begin
            uf_a = i_enp && i_ent && (m_qa == 8'h00) && !i_load;
            uf_w = i_enp && i_ent && (m_qw == 8'h00) && !i_load;
            if (i_load)               m_qa = i_lv;
            else if (uf_a)            m_qa = m_rel;
            else if (i_enp && i_ent)  m_qa = m_qa - 8'd1;
            if (i_load)               m_qw = i_lv;
            else if (uf_w)            m_qw = 8'hFF;
            else if (i_enp && i_ent)  m_qw = m_qw - 8'd1;
            m_zpa = uf_a;
            m_zpw = uf_w;
            if (i_rwe) m_rel = i_rv;
        end
        ea = '{q: m_qa, zp: m_zpa, busy: (m_qa != 0)};
        ew = '{q: m_qw, zp: m_zpw, busy: (m_qw != 0)};
        exp_a_q.push_back(ea);
        exp_w_q.push_back(ew);

        @(posedge clk);
        #1;
        pa = exp_a_q.pop_front();
        pw = exp_w_q.pop_front();
        check({tag, ".q_a"},    {24'd0, q_a},     {24'd0, pa.q});
        check({tag, ".zp_a"},   {31'd0, zp_a},    {31'd0, pa.zp});
        check({tag, ".busy_a"}, {31'd0, busy_a},  {31'd0, pa.busy});
        check({tag, ".q_w"},    {24'd0, q_w},     {24'd0, pw.q});
        check({tag, ".zp_w"},   {31'd0, zp_w},    {31'd0, pw.zp});
        check({tag, ".busy_w"}, {31'd0, busy_w},  {31'd0, pw.busy});
    endtask

    initial begin
        // Reset and idle
        @(posedge clk); #1;
        step(1, 0, 8'h00, 0, 8'h00, 0, 0, "rst0");
        step(1, 0, 8'h00, 0, 8'h00, 0, 0, "rst1");
        step(0, 0, 8'h00, 0, 8'h00, 0, 0, "idle_ent0");
        step(0, 0, 8'h00, 0, 8'h00, 0, 1, "idle_ent1");
        check("idle.q_const", {24'd0, q_a}, 32'h00);

        // Load 0x13 then count across the slice boundary
        step(0, 1, 8'h13, 0, 8'h00, 0, 0, "load13");
        check("load13.q", {24'd0, q_a}, 32'h13);
        step(0, 0, 8'h00, 0, 8'h00, 1, 1, "dec12");
        step(0, 0, 8'h00, 0, 8'h00, 1, 1, "dec11");
        step(0, 0, 8'h00, 0, 8'h00, 1, 1, "dec10");
        step(0, 0, 8'h00, 0, 8'h00, 1, 1, "borrow0f");
        check("borrow.q", {24'd0, q_a}, 32'h0F);

        // Underflow: reload 0x05 vs wrap to 0xFF
        step(0, 0, 8'h00, 1, 8'h05, 0, 0, "wr_rel05");
        step(0, 1, 8'h01, 0, 8'h00, 0, 0, "load01");
        step(0, 0, 8'h00, 0, 8'h00, 1, 1, "to_zero");
        step(0, 0, 8'h00, 0, 8'h00, 1, 1, "underflow");
        check("reload.q", {24'd0, q_a}, 32'h05);
        check("wrap.q",   {24'd0, q_w}, 32'hFF);
        check("reload.zp", {31'd0, zp_a}, 32'd1);
        step(0, 0, 8'h00, 0, 8'h00, 1, 1, "after_uf");
        check("after_uf.zp", {31'd0, zp_a}, 32'd0);

        // Load wins over underflow at q = 0
        step(0, 1, 8'h00, 0, 8'h00, 0, 0, "load00");
        step(0, 1, 8'h40, 0, 8'h00, 1, 1, "load_vs_uf");
        check("load_vs_uf.q", {24'd0, q_a}, 32'h40);

        // Same-edge reload write with underflow uses the old value
        step(0, 1, 8'h00, 0, 8'h00, 0, 0, "load00b");
        step(0, 0, 8'h00, 1, 8'h22, 1, 1, "uf_with_we");
        check("uf_with_we.q", {24'd0, q_a}, 32'h05);
        step(0, 1, 8'h00, 0, 8'h00, 0, 0, "load00c");
        step(0, 0, 8'h00, 0, 8'h00, 1, 1, "uf_new_rel");
        check("uf_new_rel.q", {24'd0, q_a}, 32'h22);

        // Reset overrides load and count mid-operation
        step(0, 1, 8'h37, 0, 8'h00, 0, 0, "load37");
        step(1, 1, 8'h55, 1, 8'h77, 1, 1, "rst_mid");
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0, 8'h00, 0, 1, "hold_zero");
        step(0, 0, 8'h00, 0, 8'h00, 1, 1, "uf_rel0");
        check("rst_mid.rel", {24'd0, q_a}, 32'h00);

        // Hold with a non-zero value
        step(0, 1, 8'h37, 0, 8'h00, 0, 0, "load37b");
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0, 8'h00, 0, 1, "hold37");
        check("hold37.q", {24'd0, q_a}, 32'h37);

        // Reload 0 with auto-reload: pulse every enabled cycle
        step(0, 1, 8'h00, 1, 8'h00, 0, 0, "load0_rel0");
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 8'h00, 1, 1, "rel0_pulse");
        check("rel0.zp", {31'd0, zp_a}, 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 11) == 0),
                 8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0),
                 8'($urandom_range(0, 20)), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 5) != 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
